// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Produces a packed-BCD word that is held stable between conversions.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH  = 27,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] encoded
);

    // state   | meaning
    // IDLE    | waiting for start, outputs hold last result
    // CONVERT | one add-3/shift step per edge, BIN_WIDTH steps
    // FINISH  | publish result, pulse done

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SR_W  = BCD_W + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] max_decimal(input int digits);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < digits; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

    localparam logic [63:0]      MAX_DEC    = max_decimal(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_adj;
    logic              ovf_flag;
    logic              in_over;

    // Full-width compare; folds to constant 0 when the input range fits the digits.
    assign in_over = 64'(bin_in) > MAX_DEC;

    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sr[BIN_WIDTH + 4*i +: 4] >= 4'd5) begin
                sr_adj[BIN_WIDTH + 4*i +: 4] = sr[BIN_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    assign busy = (state == CONVERT) || (state == FINISH);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            ovf_flag <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            encoded  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr       <= {{BCD_W{1'b0}}, bin_in};
                        cnt      <= '0;
                        ovf_flag <= in_over;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    // Top-nibble carries fall off here; only possible when overflowing.
                    sr  <= {sr_adj[SR_W-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_SHIFT) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    encoded  <= ovf_flag ? {NUM_DIGITS{4'h9}} : sr[SR_W-1 -: BCD_W];
                    overflow <= ovf_flag;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
